serial_addsub: RTL and testbench



---
 rtl/serial_addsub_pkg.sv | 15 +
 rtl/serial_addsub_fa_cell.sv | 16 +
 rtl/serial_addsub.sv | 121 ++++++++++++
 tb/tb_serial_addsub.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Width of the bit counter needed to index WIDTH bits.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// Combinational 1-bit full adder, the only arithmetic element of the datapath.
module fa_cell (
  input  logic x_i,
  input  logic y_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  // Sum and carry of a single bit position.
  always_comb begin
    s_o  = x_i ^ y_i ^ ci_i;
    co_o = (x_i & y_i) | (x_i & ci_i) | (y_i & ci_i);
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: operands are consumed LSB-first, one bit per clock,
// through a single full-adder cell and a carry flip-flop.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             co_o,
  output logic             ovf_o
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic fa_s, fa_co;

  fa_cell u_fa_cell (
    .x_i  (a_q[0]),
    .y_i  (b_q[0]),
    .ci_i (c_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // State, datapath and result registers; reset also discards any held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: accept in IDLE/DONE, shift one bit per RUN cycle, publish on the last bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d = StRun;
          a_d     = a_i;
          // Subtraction is a + ~b + 1; the +1 enters through the carry flop.
          b_d     = sub_i ? ~b_i : b_i;
          c_d     = sub_i;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_co;
        res_d = {fa_s, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          state_d = StDone;
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          co_d    = fa_co;
          // c_q is the carry into the MSB on this cycle.
          ovf_d   = c_q ^ fa_co;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake flags decode directly from the state register.
  always_comb begin
    busy_o = (state_q == StRun);
    done_o = (state_q == StDone);
    sum_o  = sum_q;
    co_o   = co_q;
    ovf_o  = ovf_q;
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: cycle-level reference model plus directed cases.
module tb_serial_addsub;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         co;
  logic         ovf;

  int n_chk  = 0;
  int n_fail = 0;

  serial_addsub #(
    .WIDTH (W)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .sub_i   (sub),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (done),
    .sum_o   (sum),
    .co_o    (co),
    .ovf_o   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the integer definitions.
  function automatic logic [W-1:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
    return s ? x - y : x + y;
  endfunction

  function automatic logic ref_co(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W:0] full;
    full = {1'b0, x} + {1'b0, y};
    return s ? (x >= y) : full[W];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s);
    longint sx, sy, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = s ? sx - sy : sx + sy;
    return (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
  endfunction

  // Timeline model: an accepted start keeps the unit busy for W cycles, then done for one.
  int           m_left;
  logic         m_done;
  logic [W-1:0] m_sum, p_sum;
  logic         m_co, p_co, m_ovf, p_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_co   <= 1'b0;
      m_ovf  <= 1'b0;
      p_sum  <= '0;
      p_co   <= 1'b0;
      p_ovf  <= 1'b0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_sum  <= p_sum;
        m_co   <= p_co;
        m_ovf  <= p_ovf;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_left <= W;
        p_sum  <= ref_sum(a, b, sub);
        p_co   <= ref_co(a, b, sub);
        p_ovf  <= ref_ovf(a, b, sub);
      end
    end
  end

  // Every cycle, all outputs must match the model.
  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_left != 0));
    chk("done", 64'(done), 64'(m_done));
    chk("sum", 64'(sum), 64'(m_sum));
    chk("co", 64'(co), 64'(m_co));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    if (busy && done) chk("busy_and_done", 64'(1), 64'(0));
  end

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                        input logic [W-1:0] es, input logic ec, input logic ev);
    int n;
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("latency", 64'(n), 64'(W + 1));
    chk("lit_sum", 64'(sum), 64'(es));
    chk("lit_co", 64'(co), 64'(ec));
    chk("lit_ovf", 64'(ovf), 64'(ev));
  endtask

  initial begin
    int n;
    logic [W-1:0] hs;
    logic hc, hv;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_sum", 64'(sum), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic cases
    run_op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // start pulsed during RUN with other operands is ignored
    @(negedge clk);
    a = 8'h3C; b = 8'h0F; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("ign_sum", 64'(sum), 64'(8'h4B));
    chk("ign_co", 64'(co), 64'(0));
    @(negedge clk);
    chk("ign_idle", 64'(busy), 64'(0));

    // start held through DONE: back-to-back without an IDLE cycle
    a = 8'h7F; b = 8'h01; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    wait_done(n);
    chk("b2b_sum1", 64'(sum), 64'(8'h80));
    chk("b2b_ovf1", 64'(ovf), 64'(1));
    a = 8'h05; b = 8'h07; sub = 1'b1;
    @(negedge clk);
    chk("b2b_busy", 64'(busy), 64'(1));
    wait_done(n);
    start = 1'b0;
    chk("b2b_period", 64'(n), 64'(W + 1));
    chk("b2b_sum2", 64'(sum), 64'(8'hFE));
    chk("b2b_co2", 64'(co), 64'(0));

    // Results hold while operands wander without start
    hs = sum; hc = co; hv = ovf;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      chk("hold_sum", 64'(sum), 64'(8'hFE));
      chk("hold_flags", 64'({co, ovf}), 64'({hc, hv}));
    end
    chk("hold_sum_end", 64'(sum), 64'(hs));

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_sum", 64'(sum), 64'(0));
    chk("arst_co", 64'(co), 64'(0));
    chk("arst_ovf", 64'(ovf), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_idle", 64'(busy), 64'(0));

    // Randomized traffic, including starts during RUN and held starts
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
      sub   = 1'($urandom);
    end
    start = 1'b0;
    repeat (W + 3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
